mc_ctrl_fsm: RTL and testbench

//  Multi-cycle CPU main control FSM. Sequences the shared datapath (PC, IR, regfile, ALU, immediate extender) per instruction.

---
 rtl/mc_ctrl_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU main control FSM: sequences fetch/decode/execute/memory/writeback,
// handles memory wait handshakes, traps on illegal opcodes or memory timeouts, counts retirements.
module mc_ctrl_fsm #(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             reg_dst,
  output logic             mem2reg,
  output logic             reg_we,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [1:0]       ext_op,
  output logic [3:0]       state,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EX     = 4'd10,
    S_I_WB     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_t            cur_state;
  state_t            nxt_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              in_mem_state;
  logic              wait_expired;
  logic              retire;
  logic [1:0]        trap_cause;
  logic              pc_write;
  logic              pc_write_cond;

  assign in_mem_state = (cur_state == S_FETCH) || (cur_state == S_MEM_RD) ||
                        (cur_state == S_MEM_WR);

  // Timeout fires on the WAIT_LIMIT-th consecutive stalled cycle; mem_ready=1 always wins.
  assign wait_expired = (WAIT_LIMIT > 0) && in_mem_state && !mem_ready &&
                        ((32'(wait_cnt) + 32'd1) >= 32'(WAIT_LIMIT));

  assign retire = (nxt_state == S_FETCH) &&
                  (cur_state inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_I_WB});

  assign state = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_FETCH;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      err       <= ERR_NONE;
      instr_cnt <= '0;
    end else begin
      if ((nxt_state != cur_state) || !in_mem_state) begin
        wait_cnt <= '0;
      end else if (!mem_ready && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if ((err == ERR_NONE) && (trap_cause != ERR_NONE)) begin
        err <= trap_cause;
      end
      if (retire) begin
        instr_cnt <= instr_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    trap_cause = ERR_NONE;
    case (cur_state)
      S_FETCH: begin
        if (mem_ready) begin
          nxt_state = S_DECODE;
        end else if (wait_expired) begin
          nxt_state  = S_TRAP;
          trap_cause = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_RTYPE:                 nxt_state = S_R_EX;
          OP_LW, OP_SW:             nxt_state = S_MEM_ADDR;
          OP_BEQ:                   nxt_state = S_BRANCH;
          OP_J:                     nxt_state = S_JUMP;
          OP_ADDI, OP_ORI, OP_LUI:  nxt_state = S_I_EX;
          default: begin
            nxt_state  = S_TRAP;
            trap_cause = ERR_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: nxt_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready) begin
          nxt_state = S_MEM_WB;
        end else if (wait_expired) begin
          nxt_state  = S_TRAP;
          trap_cause = ERR_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          nxt_state = S_FETCH;
        end else if (wait_expired) begin
          nxt_state  = S_TRAP;
          trap_cause = ERR_TIMEOUT;
        end
      end
      S_R_EX:   nxt_state = S_R_WB;
      S_I_EX:   nxt_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: nxt_state = S_FETCH;
      S_TRAP:   nxt_state = S_TRAP;
      default:  nxt_state = S_FETCH;
    endcase
  end

  // Decoding is gated by rst_n so every control output drops the moment reset asserts.
  always_comb begin
    iord          = 1'b0;
    mem_rd        = 1'b0;
    mem_wr        = 1'b0;
    ir_we         = 1'b0;
    reg_dst       = 1'b0;
    mem2reg       = 1'b0;
    reg_we        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    ext_op        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    if (rst_n) begin
      case (cur_state)
        S_FETCH: begin
          mem_rd    = 1'b1;
          alu_src_b = 2'b01;
          ir_we     = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
        end
        S_MEM_WB: begin
          reg_we  = 1'b1;
          mem2reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
        end
        S_R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_we  = 1'b1;
          reg_dst = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_src        = 2'b01;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'b10;
        end
        S_I_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          case (op)
            OP_ORI: begin
              alu_op = 2'b11;
              ext_op = 2'b01;
            end
            OP_LUI:  ext_op = 2'b10;
            default: ext_op = 2'b00;
          endcase
        end
        S_I_WB: begin
          reg_we = 1'b1;
        end
        default: ;
      endcase
    end
    pc_we = pc_write | (pc_write_cond & zero);
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: per-instruction state paths built from opcode class
// and wait counts, outputs checked against a per-state control-word table.
module tb_mc_ctrl_fsm;

  localparam int CNT_W      = 4;
  localparam int WAIT_LIMIT = 16;
  localparam int TRAP_ST    = 12;

  // {pc_we,iord,mem_rd,mem_wr,ir_we,reg_dst,mem2reg,reg_we,src_a,src_b,alu_op,pc_src,ext_op}
  localparam logic [16:0] CTRL_TBL [13] = '{
    17'b0_0_1_0_0_0_0_0_0_01_00_00_00,  // FETCH (pc_we/ir_we added when mem_ready)
    17'b0_0_0_0_0_0_0_0_0_11_00_00_00,  // DECODE
    17'b0_0_0_0_0_0_0_0_1_10_00_00_00,  // MEM_ADDR
    17'b0_1_1_0_0_0_0_0_0_00_00_00_00,  // MEM_RD
    17'b0_0_0_0_0_0_1_1_0_00_00_00_00,  // MEM_WB
    17'b0_1_0_1_0_0_0_0_0_00_00_00_00,  // MEM_WR
    17'b0_0_0_0_0_0_0_0_1_00_10_00_00,  // R_EX
    17'b0_0_0_0_0_1_0_1_0_00_00_00_00,  // R_WB
    17'b0_0_0_0_0_0_0_0_1_00_01_01_00,  // BRANCH (pc_we added when zero)
    17'b1_0_0_0_0_0_0_0_0_00_00_10_00,  // JUMP
    17'b0_0_0_0_0_0_0_0_1_10_00_00_00,  // I_EX (alu_op/ext_op depend on op)
    17'b0_0_0_0_0_0_0_1_0_00_00_00_00,  // I_WB
    17'b0_0_0_0_0_0_0_0_0_00_00_00_00   // TRAP
  };

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       op = '0;
  logic             zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem2reg, reg_we, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_src, ext_op, err;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic [16:0]      ctrl_obs;

  int checks = 0;
  int failures = 0;
  int model_cnt = 0;
  int model_err = 0;
  int path[$];

  mc_ctrl_fsm #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_we(ir_we),
    .reg_dst(reg_dst), .mem2reg(mem2reg), .reg_we(reg_we), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .ext_op(ext_op),
    .state(state), .err(err), .instr_cnt(instr_cnt)
  );

  assign ctrl_obs = {pc_we, iord, mem_rd, mem_wr, ir_we, reg_dst, mem2reg, reg_we,
                     alu_src_a, alu_src_b, alu_op, pc_src, ext_op};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] o,
                                           input logic mr, input logic z);
    logic [16:0] w;
    w = CTRL_TBL[st];
    if (st == 0 && mr) w = w | 17'h10000 | 17'h01000;
    if (st == 8 && z)  w = w | 17'h10000;
    if (st == 10) begin
      if (o == 6'b001101) w = w | 17'h00031;
      if (o == 6'b001111) w = w | 17'h00002;
    end
    return w;
  endfunction

  // Builds the expected state sequence for one instruction; trap_code != 0 means it ends in TRAP.
  task automatic build_path(input logic [5:0] o, input int fw, input int dw, output int trap_code);
    int data_st;
    path.delete();
    trap_code = 0;
    if (fw >= WAIT_LIMIT) begin
      repeat (WAIT_LIMIT) path.push_back(0);
      trap_code = 2;
      return;
    end
    repeat (fw + 1) path.push_back(0);
    path.push_back(1);
    case (o)
      6'b000000: begin path.push_back(6); path.push_back(7); end
      6'b100011, 6'b101011: begin
        data_st = (o == 6'b100011) ? 3 : 5;
        path.push_back(2);
        if (dw >= WAIT_LIMIT) begin
          repeat (WAIT_LIMIT) path.push_back(data_st);
          trap_code = 2;
        end else begin
          repeat (dw + 1) path.push_back(data_st);
          if (data_st == 3) path.push_back(4);
        end
      end
      6'b000100: path.push_back(8);
      6'b000010: path.push_back(9);
      6'b001000, 6'b001101, 6'b001111: begin path.push_back(10); path.push_back(11); end
      default: trap_code = 1;
    endcase
  endtask

  // Entered and left at a falling edge. zf: 0/1 forces zero, 2 randomizes it each cycle.
  task automatic run_instr(input logic [5:0] o, input int fw, input int dw, input int zf,
                           input int abort_at, input int hold);
    int trap_code;
    int data_idx;
    int st;
    build_path(o, fw, dw, trap_code);
    data_idx = 0;
    for (int i = 0; i < path.size(); i++) begin
      st = path[i];
      op = (st == 0) ? 6'($urandom) : o;
      zero = (zf == 2) ? 1'($urandom) : 1'(zf);
      if (st == 0) begin
        mem_ready = (i == fw);
      end else if (st == 3 || st == 5) begin
        mem_ready = (data_idx == dw);
        data_idx++;
      end else begin
        mem_ready = 1'($urandom);
      end
      #1;
      check("state", 32'(state), 32'(st));
      check("ctrl", 32'(ctrl_obs), 32'(exp_ctrl(st, o, mem_ready, zero)));
      check("err", 32'(err), 32'(model_err));
      check("cnt", 32'(instr_cnt), 32'(model_cnt));
      if (i == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        check("abort_mem_wr", 32'(mem_wr), 32'd0);
        check("abort_ctrl", 32'(ctrl_obs), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        model_cnt = 0;
        model_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
    end
    if (trap_code != 0) begin
      if (model_err == 0) model_err = trap_code;
      for (int k = 0; k < hold; k++) begin
        op = 6'($urandom);
        zero = 1'($urandom);
        mem_ready = 1'($urandom);
        #1;
        check("trap_state", 32'(state), 32'(TRAP_ST));
        check("trap_ctrl", 32'(ctrl_obs), 32'd0);
        check("trap_err", 32'(err), 32'(model_err));
        check("trap_cnt", 32'(instr_cnt), 32'(model_cnt));
        @(negedge clk);
      end
    end else begin
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom);
    #1;
    check("rst_ctrl", 32'(ctrl_obs), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    model_cnt = 0;
    model_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] legal [8];
    logic [5:0] o;
    int fw;
    int dw;
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000010, 6'b001000, 6'b001101, 6'b001111};

    @(negedge clk);
    do_reset();

    run_instr(6'b000000, 0, 0, 2, -1, 0);
    run_instr(6'b100011, 0, 3, 2, -1, 0);
    run_instr(6'b001101, 0, 0, 2, -1, 0);
    run_instr(6'b001111, 1, 0, 2, -1, 0);
    run_instr(6'b001000, 0, 0, 2, -1, 0);
    run_instr(6'b000100, 0, 0, 1, -1, 0);
    run_instr(6'b000100, 0, 0, 0, -1, 0);
    run_instr(6'b000010, 2, 0, 2, -1, 0);
    run_instr(6'b101011, 0, 2, 2, -1, 0);
    // One short of the timeout: must still advance
    run_instr(6'b000000, WAIT_LIMIT - 1, 0, 2, -1, 0);
    run_instr(6'b100011, 0, WAIT_LIMIT - 1, 2, -1, 0);
    run_instr(6'b101011, WAIT_LIMIT - 1, WAIT_LIMIT - 1, 2, -1, 0);

    for (int n = 0; n < 150; n++) begin
      o = legal[$urandom_range(0, 7)];
      fw = ($urandom_range(0, 9) == 0) ? WAIT_LIMIT - 1 : int'($urandom_range(0, 3));
      dw = ($urandom_range(0, 9) == 0) ? WAIT_LIMIT - 1 : int'($urandom_range(0, 3));
      run_instr(o, fw, dw, 2, -1, 0);
    end

    do_reset();
    repeat (16) run_instr(6'b000010, 0, 0, 2, -1, 0);
    #1 check("cnt_wrap", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    do_reset();

    run_instr(6'b111111, 0, 0, 2, -1, 20);
    do_reset();
    run_instr(6'(6'b010000 | 6'($urandom_range(0, 15))), 1, 0, 2, -1, 5);
    do_reset();
    run_instr(6'b000000, WAIT_LIMIT, 0, 2, -1, 10);
    do_reset();
    run_instr(6'b100011, 0, WAIT_LIMIT, 2, -1, 6);
    do_reset();
    run_instr(6'b101011, 2, WAIT_LIMIT, 2, -1, 6);
    do_reset();

    run_instr(6'b001000, 0, 0, 2, -1, 0);
    run_instr(6'b101011, 0, 3, 2, 4, 0);
    run_instr(6'b000000, 0, 0, 2, -1, 0);
    run_instr(6'b100011, 1, 1, 2, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
